instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 172 +++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch unit with prefetch buffer and redirect
//
// Purpose: fetches instruction words from a ROM with a registered 1-cycle read
// latency. Captured words go into a DEPTH-entry buffer that the consumer drains
// with a valid/ready handshake. A redirect flushes the buffer and restarts
// fetch at a word-aligned target.
//
// Optional feature: when the macro FETCH_HALT_ON_ZERO_EN is defined, a
// captured zero word is buffered and stops fetch (HALT) until the next
// redirect. The HALTED output exists only in that build.
//
// Timing: cycles are counted as rising edges after reset release. Edge 1
// leaves BOOT and raises ROM_REQ. Edge 2 is when the ROM samples the request.
// Edge 3 captures the word, so OUT_VALID rises at edge 3.
//
// Parameters:
//   WIDTH     address / instruction width
//   DEPTH     buffer entries (power of 2, >= 2)
//   RESET_PC  byte address of the first fetch
// Ports:
//   CLK          clock, rising edge
//   RESET        asynchronous active-high reset
//   ROM_ADDRESS  registered fetch byte address
//   ROM_REQ      ROM_ADDRESS is a real request this cycle
//   ROM_INSTR    ROM word, valid the cycle after its request
//   OUT_VALID    head-of-buffer entry is valid
//   OUT_READY    consumer accepts the head entry
//   OUT_INSTR    head instruction (0 when empty)
//   OUT_PC       byte address of OUT_INSTR (0 when empty)
//   REDIRECT     single-cycle branch/jump request
//   REDIRECT_PC  new fetch address, sampled with REDIRECT
//   HALTED       fetch stopped on a zero word (FETCH_HALT_ON_ZERO_EN only)

module instr_fetch_unit #(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             CLK,
  input  logic             RESET,
  output logic [WIDTH-1:0] ROM_ADDRESS,
  output logic             ROM_REQ,
  input  logic [WIDTH-1:0] ROM_INSTR,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT_INSTR,
  output logic [WIDTH-1:0] OUT_PC,
  input  logic             REDIRECT,
  input  logic [WIDTH-1:0] REDIRECT_PC
`ifdef FETCH_HALT_ON_ZERO_EN
  ,
  output logic             HALTED
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN
`ifdef FETCH_HALT_ON_ZERO_EN
    ,
    S_HALT
`endif
  } state_t;

  state_t           state, state_next;
  logic             rom_req;
  logic             in_flight;      // response to last cycle's request arrives now
  logic [WIDTH-1:0] inflight_pc;    // address tag of that response
  logic [AW-1:0]    head, tail;
  logic [CW-1:0]    count;
  logic             redirect_pending;
  logic [WIDTH-1:0] pending_pc;

  logic [WIDTH-1:0] fifo_instr [DEPTH];
  logic [WIDTH-1:0] fifo_pc    [DEPTH];

  logic             pop, push, redir_take, issue_next;
  logic [WIDTH-1:0] redir_addr;

  // Fetch targets are word aligned; the low address bits of REDIRECT_PC are dropped.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^REDIRECT_PC[1:0];

  always_comb begin
    pop        = OUT_VALID && OUT_READY;
    // A redirect seen in BOOT is held in redirect_pending and acted on one cycle later.
    redir_take = (state != S_BOOT) && (REDIRECT || redirect_pending);
    redir_addr = REDIRECT ? {REDIRECT_PC[WIDTH-1:2], 2'b00} : pending_pc;
    // A response arriving in a redirect cycle belongs to the old stream.
    push       = in_flight && !redir_take;
    state_next = state;
    case (state)
      S_BOOT: state_next = S_RUN;
      S_RUN: begin
`ifdef FETCH_HALT_ON_ZERO_EN
        if (push && (ROM_INSTR == '0)) state_next = S_HALT;
`endif
      end
`ifdef FETCH_HALT_ON_ZERO_EN
      S_HALT: if (redir_take) state_next = S_RUN;
`endif
      default: state_next = S_BOOT;
    endcase
    // Requests alternate with responses (!rom_req), so at most one is in flight.
    // Counting the in-flight response against DEPTH means a capture always has room.
    issue_next = (state_next == S_RUN) && !rom_req && !redir_take &&
                 ((int'(count) + int'(in_flight)) < DEPTH);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state            <= S_BOOT;
      ROM_ADDRESS      <= RESET_PC;
      rom_req          <= 1'b0;
      in_flight        <= 1'b0;
      inflight_pc      <= '0;
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      redirect_pending <= 1'b0;
      pending_pc       <= '0;
    end else begin
      state <= state_next;
      if (rom_req) inflight_pc <= ROM_ADDRESS;

      if (redir_take) begin
        // Any handshake this cycle has already completed; flush everything left.
        ROM_ADDRESS <= redir_addr;
        rom_req     <= 1'b1;
        in_flight   <= 1'b0;
        head        <= '0;
        tail        <= '0;
        count       <= '0;
      end else begin
        if (rom_req) ROM_ADDRESS <= ROM_ADDRESS + WIDTH'(4);
        rom_req   <= issue_next;
        in_flight <= rom_req;
        if (push) tail <= tail + AW'(1);
        if (pop)  head <= head + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end

      if ((state == S_BOOT) && REDIRECT) begin
        redirect_pending <= 1'b1;
        pending_pc       <= {REDIRECT_PC[WIDTH-1:2], 2'b00};
      end else if (redir_take) begin
        redirect_pending <= 1'b0;
      end
    end
  end

  // Storage needs no reset: entries are only visible through a non-zero count.
  always_ff @(posedge CLK) begin
    if (push && !RESET) begin
      fifo_instr[tail] <= ROM_INSTR;
      fifo_pc[tail]    <= inflight_pc;
    end
  end

  assign ROM_REQ   = rom_req;
  assign OUT_VALID = (count != '0);
  assign OUT_INSTR = OUT_VALID ? fifo_instr[head] : '0;
  assign OUT_PC    = OUT_VALID ? fifo_pc[head]    : '0;

`ifdef FETCH_HALT_ON_ZERO_EN
  assign HALTED = (state == S_HALT);
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
`timescale 1ns/100ps

module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] rom_address, out_instr, out_pc;
  logic [31:0] rom_instr = '0;
  logic        rom_req, out_valid;

  logic        rst_b = 1'b1;
  logic [31:0] rom_address_b, out_instr_b, out_pc_b;
  logic [31:0] rom_instr_b = '0;
  logic        rom_req_b, out_valid_b;

`ifdef FETCH_HALT_ON_ZERO_EN
  logic halted, halted_b;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch_unit #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .CLK(clk), .RESET(rst),
    .ROM_ADDRESS(rom_address), .ROM_REQ(rom_req), .ROM_INSTR(rom_instr),
    .OUT_VALID(out_valid), .OUT_READY(ready), .OUT_INSTR(out_instr), .OUT_PC(out_pc),
    .REDIRECT(redirect), .REDIRECT_PC(redirect_pc)
`ifdef FETCH_HALT_ON_ZERO_EN
    , .HALTED(halted)
`endif
  );

  instr_fetch_unit #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .CLK(clk), .RESET(rst_b),
    .ROM_ADDRESS(rom_address_b), .ROM_REQ(rom_req_b), .ROM_INSTR(rom_instr_b),
    .OUT_VALID(out_valid_b), .OUT_READY(1'b1), .OUT_INSTR(out_instr_b), .OUT_PC(out_pc_b),
    .REDIRECT(1'b0), .REDIRECT_PC(32'h0)
`ifdef FETCH_HALT_ON_ZERO_EN
    , .HALTED(halted_b)
`endif
  );

  // ROM contents: word k holds k+1 (so 0,4,8,C hold 1,2,3,4), except 0x10 holds 0.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    rom_word = (a == 32'h10) ? 32'h0 : (a >> 2) + 32'd1;
  endfunction

  always @(posedge clk) if (rom_req)   rom_instr   <= rom_word(rom_address);
  always @(posedge clk) if (rom_req_b) rom_instr_b <= rom_word(rom_address_b);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for the head entry, check it, and let the handshake take it.
  task automatic pop_expect(input string tag, input logic [31:0] pc);
    int n = 0;
    while (!out_valid && n < 12) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_pc"}, out_pc, pc);
    check({tag, "_instr"}, out_instr, rom_word(pc));
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] base;
    logic [31:0] wrap_pcs [3];
    wrap_pcs[0] = 32'hFFFF_FFF8;
    wrap_pcs[1] = 32'hFFFF_FFFC;
    wrap_pcs[2] = 32'h0000_0000;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_rom_address", rom_address, 32'h0);
    check("rst_rom_req", 32'(rom_req), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_wrap_rom_address", rom_address_b, 32'hFFFF_FFF8);
`ifdef FETCH_HALT_ON_ZERO_EN
    check("rst_halted", 32'(halted), 32'd0);
`endif

    // In-order stream 1,2,3,4 with first OUT_VALID at edge 3
    rst   = 1'b0;
    ready = 1'b1;
    @(negedge clk);
    check("boot_rom_req", 32'(rom_req), 32'd1);
    check("boot_rom_address", rom_address, 32'h0);
    check("boot_valid_e1", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("valid_e2", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("valid_e3", 32'(out_valid), 32'd1);
    pop_expect("s0", 32'h0);
    pop_expect("s4", 32'h4);
    pop_expect("s8", 32'h8);
    pop_expect("sc", 32'hC);

    // Redirect to 0xB while the 0x10 response is in flight
    check("pre_redir_rom_address", rom_address, 32'h14);
    check("pre_redir_rom_req", 32'(rom_req), 32'd0);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_000B;
    @(posedge clk);
    @(negedge clk);
    redirect = 1'b0;
    check("redir_rom_address", rom_address, 32'h8);
    check("redir_rom_req", 32'(rom_req), 32'd1);
    check("redir_flush_valid", 32'(out_valid), 32'd0);
    pop_expect("r8", 32'h8);
    pop_expect("rc", 32'hC);
    pop_expect("r10_zero", 32'h10);

`ifdef FETCH_HALT_ON_ZERO_EN
    check("halt_halted", 32'(halted), 32'd1);
    repeat (6) @(negedge clk);
    check("halt_no_req", 32'(rom_req), 32'd0);
    check("halt_drained", 32'(out_valid), 32'd0);
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    @(posedge clk);
    @(negedge clk);
    redirect = 1'b0;
    check("resume_halted", 32'(halted), 32'd0);
    check("resume_rom_req", 32'(rom_req), 32'd1);
    check("resume_rom_address", rom_address, 32'h40);
    pop_expect("h40", 32'h40);
    base = 32'h44;
`else
    pop_expect("r14", 32'h14);
    base = 32'h18;
`endif

    // Backpressure: fill exactly DEPTH entries, then no more requests
    ready = 1'b0;
    repeat (20) @(negedge clk);
    check("stall_valid", 32'(out_valid), 32'd1);
    check("stall_rom_req", 32'(rom_req), 32'd0);
    check("stall_pc", out_pc, base);
    check("stall_instr", out_instr, rom_word(base));
    repeat (3) @(negedge clk);
    check("stall_pc_stable", out_pc, base);
    check("stall_instr_stable", out_instr, rom_word(base));
    ready = 1'b1;
    for (int i = 0; i < 5; i++) pop_expect("drain", base + 32'(4 * i));

    // Short asynchronous reset between clock edges
    for (int i = 0; i < 12 && !out_valid; i++) @(negedge clk);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #1 rst = 1'b1;
    #0.5;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_rom_req", 32'(rom_req), 32'd0);
    check("async_rst_rom_address", rom_address, 32'h0);
    check("async_rst_pc", out_pc, 32'h0);
    #0.5 rst = 1'b0;
    @(negedge clk);
    check("restart_rom_req", 32'(rom_req), 32'd1);
    check("restart_rom_address", rom_address, 32'h0);
    pop_expect("restart0", 32'h0);
    pop_expect("restart4", 32'h4);

    // Address wrap from RESET_PC 0xFFFFFFF8
    rst_b = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 12 && !out_valid_b; i++) @(negedge clk);
      check("wrap_valid", 32'(out_valid_b), 32'd1);
      check("wrap_pc", out_pc_b, wrap_pcs[k]);
      check("wrap_instr", out_instr_b, rom_word(wrap_pcs[k]));
      @(posedge clk);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
